// File: rtl/usb_tx_turnaround.sv
`default_nettype none
// ============================================================================
// Module   : usb_tx_turnaround
// Brief    : Full-speed SIE transmit turnaround / inter-packet-delay control.
//            Holds off TX until the minimum gap after any bus EOP has
//            elapsed. After a received packet it tracks the device response
//            window and flags a missed response.
// Revision : 1.0 - initial release
// ============================================================================
module usb_tx_turnaround #(
    parameter int MIN_GAP_TICKS  = 8,
    parameter int MAX_RESP_TICKS = 26
) (
    input  logic clk48_i,
    input  logic rst_i,
    input  logic rxEop_i,
    input  logic txEop_i,
    input  logic txReq_i,
    output logic txGo_o,
    output logic windowOpen_o,
    output logic respMissed_o
);

    localparam int CNT_WID = $clog2(MAX_RESP_TICKS);

    // Last gap count before TX may start, and last count of the response window
    localparam logic [CNT_WID-1:0] C_GAP_LAST  = CNT_WID'(MIN_GAP_TICKS - 1);
    localparam logic [CNT_WID-1:0] C_RESP_LAST = CNT_WID'(MAX_RESP_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RX_GAP  = 2'd1,
        S_TX_BUSY = 2'd2,
        S_TX_GAP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_WID-1:0] r_cnt;
    logic [CNT_WID-1:0] w_cnt_nxt;
    logic               r_go;
    logic               w_go_nxt;
    logic               r_missed;
    logic               w_missed_nxt;
    logic               w_gap_met;
    logic               w_in_gap;

    assign w_gap_met = (r_cnt >= C_GAP_LAST);
    assign w_in_gap  = (r_state == S_RX_GAP) || (r_state == S_TX_GAP);

    // State, gap counter and pulse outputs
    always_ff @(posedge clk48_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_go     <= 1'b0;
            r_missed <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_go     <= w_go_nxt;
            r_missed <= w_missed_nxt;
        end
    end

    // Next-state, counter and grant/deadline decisions.
    // The cycle in which txGo_o is high is a commit cycle: the FSM holds its
    // current state (so an open response window stays visible alongside the
    // grant) and then enters TX_BUSY unconditionally. This also guarantees a
    // single grant per request and keeps txGo_o and respMissed_o exclusive.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_go_nxt     = 1'b0;
        w_missed_nxt = 1'b0;

        // Saturating count while a gap is being timed
        if (w_in_gap && (r_cnt != C_RESP_LAST)) begin
            w_cnt_nxt = r_cnt + CNT_WID'(1);
        end

        if (r_go) begin
            w_state_nxt = S_TX_BUSY;
        end else begin
            unique case (r_state)
                S_TX_BUSY: begin
                    // Bus is ours; only our own EOP ends this state
                    if (txEop_i) begin
                        w_state_nxt = S_TX_GAP;
                        w_cnt_nxt   = '0;
                    end
                end
                S_IDLE: begin
                    if (rxEop_i) begin
                        w_state_nxt = S_RX_GAP;
                        w_cnt_nxt   = '0;
                    end else if (txReq_i) begin
                        w_go_nxt = 1'b1;
                    end
                end
                S_RX_GAP: begin
                    if (rxEop_i) begin
                        w_cnt_nxt = '0;
                    end else if (txReq_i && w_gap_met) begin
                        w_go_nxt = 1'b1;
                    end else if (r_cnt == C_RESP_LAST) begin
                        w_missed_nxt = 1'b1;
                        w_state_nxt  = S_IDLE;
                    end
                end
                S_TX_GAP: begin
                    if (rxEop_i) begin
                        w_state_nxt = S_RX_GAP;
                        w_cnt_nxt   = '0;
                    end else if (txReq_i && w_gap_met) begin
                        w_go_nxt = 1'b1;
                    end else if (r_cnt == C_GAP_LAST) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign txGo_o       = r_go;
    assign respMissed_o = r_missed;
    assign windowOpen_o = (r_state == S_RX_GAP) && w_gap_met;

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_turnaround.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_tx_turnaround
// Brief    : Self-checking bench for usb_tx_turnaround. An event/age based
//            reference model predicts every output each cycle; directed
//            scenarios additionally pin key latencies to literal values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_tx_turnaround;

    localparam int MIN_GAP  = 8;
    localparam int MAX_RESP = 26;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_eop = 1'b0;
    logic tx_eop = 1'b0;
    logic tx_req = 1'b0;
    logic tx_go;
    logic win;
    logic missed;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: time since the last EOP and what kind of EOP it was
    bit m_busy = 0;
    int m_kind = 0;     // 0: no gap, 1: after received EOP, 2: after own EOP
    int m_age  = 0;     // cycles elapsed since the EOP cycle
    bit e_go   = 0;
    bit e_miss = 0;

    // Per-scenario observations
    int go_first, go_last, n_go, miss_first, n_miss, win_first, win_last;

    usb_tx_turnaround #(
        .MIN_GAP_TICKS (MIN_GAP),
        .MAX_RESP_TICKS(MAX_RESP)
    ) dut (
        .clk48_i     (clk),
        .rst_i       (rst),
        .rxEop_i     (rx_eop),
        .txEop_i     (tx_eop),
        .txReq_i     (tx_req),
        .txGo_o      (tx_go),
        .windowOpen_o(win),
        .respMissed_o(missed)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance the model by one clock edge using the inputs of the ending cycle
    task automatic model_step();
        bit nxt_go;
        bit nxt_miss;
        nxt_go   = 0;
        nxt_miss = 0;
        if (rst) begin
            m_busy = 0;
            m_kind = 0;
            m_age  = 0;
        end else if (e_go) begin
            m_busy = 1;
            m_kind = 0;
        end else if (m_busy) begin
            if (tx_eop) begin
                m_busy = 0;
                m_kind = 2;
                m_age  = 0;
            end
        end else if (rx_eop) begin
            m_kind = 1;
            m_age  = 0;
        end else if (tx_req && (m_kind == 0 || m_age >= MIN_GAP)) begin
            nxt_go = 1;
        end else if (m_kind == 1 && m_age == MAX_RESP) begin
            nxt_miss = 1;
            m_kind   = 0;
        end else if (m_kind == 2 && m_age == MIN_GAP) begin
            m_kind = 0;
        end
        if (m_kind != 0) m_age++;
        e_go   = nxt_go;
        e_miss = nxt_miss;
    endtask

    // Model update and cycle count on every rising edge
    initial forever begin
        @(posedge clk);
        cyc++;
        model_step();
    end

    // Compare DUT against the model on every falling edge and log events
    initial forever begin
        @(negedge clk);
        check("tx_go", int'(tx_go), int'(e_go));
        check("resp_missed", int'(missed), int'(e_miss));
        check("window_open", int'(win), int'(m_kind == 1 && m_age >= MIN_GAP && !m_busy));
        if (tx_go) begin
            if (go_first < 0) go_first = cyc;
            go_last = cyc;
            n_go++;
        end
        if (missed) begin
            if (miss_first < 0) miss_first = cyc;
            n_miss++;
        end
        if (win) begin
            if (win_first < 0) win_first = cyc;
            win_last = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic clear_stats();
        go_first   = -1;
        go_last    = -1;
        n_go       = 0;
        miss_first = -1;
        n_miss     = 0;
        win_first  = -1;
        win_last   = -1;
    endtask

    task automatic reset_dut();
        rx_eop = 0;
        tx_eop = 0;
        tx_req = 0;
        rst    = 1;
        step();
        step();
        rst = 0;
        check("reset_go", int'(tx_go), 0);
        check("reset_win", int'(win), 0);
        check("reset_miss", int'(missed), 0);
    endtask

    // Pulse rx_eop in the current cycle; returns that cycle number
    task automatic pulse_rx(output int t);
        t      = cyc;
        rx_eop = 1;
        step();
        rx_eop = 0;
    endtask

    int t0, t1;

    initial begin
        clear_stats();
        step();

        // IDLE grant: txReq in cycle 0 only -> txGo in cycle 1
        reset_dut();
        clear_stats();
        t0     = cyc;
        tx_req = 1;
        step();
        tx_req = 0;
        run(6);
        check("idle_go_lat", go_first - t0, 1);
        check("idle_go_cnt", n_go, 1);
        check("idle_no_win", win_first, -1);

        // Received EOP with request held: grant at 9, window 8..9
        reset_dut();
        clear_stats();
        tx_req = 1;
        pulse_rx(t0);
        run(16);
        tx_req = 0;
        check("rx_go_lat", go_first - t0, 9);
        check("rx_go_cnt", n_go, 1);
        check("rx_win_first", win_first - t0, 8);
        check("rx_win_last", win_last - t0, 9);
        check("rx_no_miss", n_miss, 0);

        // Received EOP, never a request: window 8..26, miss at 27
        reset_dut();
        clear_stats();
        pulse_rx(t0);
        run(34);
        check("miss_win_first", win_first - t0, 8);
        check("miss_win_last", win_last - t0, 26);
        check("miss_lat", miss_first - t0, 27);
        check("miss_cnt", n_miss, 1);
        check("miss_no_go", n_go, 0);

        // Request rising in cycle 26: last legal grant at 27
        reset_dut();
        clear_stats();
        pulse_rx(t0);
        wait_until(t0 + 26);
        tx_req = 1;
        run(6);
        tx_req = 0;
        check("late_go_lat", go_first - t0, 27);
        check("late_no_miss", n_miss, 0);

        // Request rising in cycle 27: miss at 27, IDLE grant at 28
        reset_dut();
        clear_stats();
        pulse_rx(t0);
        wait_until(t0 + 27);
        tx_req = 1;
        run(6);
        tx_req = 0;
        check("toolate_miss", miss_first - t0, 27);
        check("toolate_go", go_first - t0, 28);

        // Own packet, EOP 20 cycles after grant, request held: next grant +9
        reset_dut();
        clear_stats();
        t0     = cyc;
        tx_req = 1;
        wait_until(t0 + 21);
        t1     = cyc;
        tx_eop = 1;
        step();
        tx_eop = 0;
        run(14);
        tx_req = 0;
        check("txgap_first_go", go_first - t0, 1);
        check("txgap_next_go", go_last - t1, 9);
        check("txgap_go_cnt", n_go, 2);

        // Own EOP with no request: back to IDLE, then immediate IDLE grant
        reset_dut();
        clear_stats();
        tx_req = 1;
        step();
        tx_req = 0;
        run(3);
        t1     = cyc;
        tx_eop = 1;
        step();
        tx_eop = 0;
        wait_until(t1 + 9);
        tx_req = 1;
        step();
        tx_req = 0;
        run(3);
        check("txgap_idle_go", go_last - t1, 10);

        // Second rxEop in cycle 5 restarts the gap
        reset_dut();
        clear_stats();
        tx_req = 1;
        pulse_rx(t0);
        wait_until(t0 + 5);
        pulse_rx(t1);
        run(14);
        tx_req = 0;
        check("restart_go_lat", go_first - t1, 9);
        check("restart_go_cnt", n_go, 1);

        // rxEop during TX_BUSY is ignored; reset from TX_BUSY clears everything
        reset_dut();
        clear_stats();
        tx_req = 1;
        step();
        tx_req = 0;
        run(3);
        pulse_rx(t0);
        run(12);
        check("busy_rx_ignored", win_first, -1);
        check("busy_go_cnt", n_go, 1);
        rst = 1;
        step();
        rst = 0;
        check("busy_rst_go", int'(tx_go), 0);
        check("busy_rst_win", int'(win), 0);

        // Reset in cycle 15 of the received-EOP gap: no miss afterwards
        clear_stats();
        pulse_rx(t0);
        wait_until(t0 + 15);
        rst = 1;
        step();
        rst = 0;
        check("gap_rst_win", int'(win), 0);
        run(30);
        check("gap_rst_win_last", win_last - t0, 15);
        check("gap_rst_no_miss", n_miss, 0);
        check("gap_rst_no_go", n_go, 0);

        run(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute time bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time bound at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire
